// File: rtl/elevator_floor_ctrl.sv
// ---------------------------------------------------------------------------
// elevator_floor_ctrl
//
// Purpose:
//   Sits upstream of the seven-segment floor display. It latches floor
//   requests and runs a SCAN-style car controller. Each move between
//   adjacent floors lasts TRAVEL_CYCLES clocks, and each stop holds the door
//   open for DOOR_CYCLES clocks.
//
// Ports:
//   clk        in   system clock, rising-edge active
//   rst_n      in   asynchronous active-low reset
//   req        in   [NUM_FLOORS] per-floor request (level or single pulse)
//   door_hold  in   keeps the door open while high (DOOR_HOLD_EN build only)
//   floor      out  [4] current floor, binary, MSB = floor[3]
//   dir_up     out  car moving up, or committed to up
//   dir_dn     out  car moving down, or committed to down
//   moving     out  high while travelling between floors
//   door_open  out  high while the door is open
//   pending    out  [NUM_FLOORS] latched, unserved requests
//
// Build option:
//   DOOR_HOLD_EN - adds the door_hold input.
// ---------------------------------------------------------------------------
module elevator_floor_ctrl #(
    parameter int NUM_FLOORS    = 10,
    parameter int TRAVEL_CYCLES = 50,
    parameter int DOOR_CYCLES   = 100
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] req,
`ifdef DOOR_HOLD_EN
    input  logic                  door_hold,
`endif
    output logic [3:0]            floor,
    output logic                  dir_up,
    output logic                  dir_dn,
    output logic                  moving,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_CYCLES - 1);
    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [3:0]    TOP_FLOOR   = 4'(NUM_FLOORS - 1);

    typedef enum logic [1:0] {S_IDLE, S_MOVE_UP, S_MOVE_DN, S_DOOR} state_t;

    state_t                  state_reg, state_next;
    logic [3:0]              floor_reg, floor_next;
    logic [TW-1:0]           timer_reg, timer_next;
    logic                    dir_up_reg, dir_up_next;
    logic                    dir_dn_reg, dir_dn_next;
    logic [NUM_FLOORS-1:0]   pending_reg, pending_next;
    logic [NUM_FLOORS-1:0]   clear;

    // Per-floor masks relative to the current floor.
    logic [NUM_FLOORS-1:0]   above_mask, below_mask, cur_oh, up_oh, dn_oh;
    // Requests already latched plus anything arriving this cycle, so a
    // request can be acted on in the same edge that samples it.
    logic [NUM_FLOORS-1:0]   eff;
    logic hit_cur, hit_up, hit_dn;
    logic above_any, below_any, above_next_any, below_next_any;

    generate
        for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_mask
            localparam logic [3:0] FI  = 4'(gi);
            localparam logic [4:0] FI5 = 5'(gi);
            assign above_mask[gi] = (FI > floor_reg);
            assign below_mask[gi] = (FI < floor_reg);
            assign cur_oh[gi]     = (FI == floor_reg);
            assign up_oh[gi]      = (({1'b0, floor_reg} + 5'd1) == FI5);
            assign dn_oh[gi]      = ({1'b0, floor_reg} == (FI5 + 5'd1));
        end
    endgenerate

    assign eff            = pending_reg | req;
    assign hit_cur        = |(eff & cur_oh);
    assign hit_up         = |(eff & up_oh);
    assign hit_dn         = |(eff & dn_oh);
    assign above_any      = |(eff & above_mask);
    assign below_any      = |(eff & below_mask);
    // Requests strictly beyond the floor being arrived at.
    assign above_next_any = |(eff & above_mask & ~up_oh);
    assign below_next_any = |(eff & below_mask & ~dn_oh);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            floor_reg   <= 4'd0;
            timer_reg   <= '0;
            dir_up_reg  <= 1'b0;
            dir_dn_reg  <= 1'b0;
            pending_reg <= '0;
        end else begin
            state_reg   <= state_next;
            floor_reg   <= floor_next;
            timer_reg   <= timer_next;
            dir_up_reg  <= dir_up_next;
            dir_dn_reg  <= dir_dn_next;
            pending_reg <= pending_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next  = state_reg;
        floor_next  = floor_reg;
        timer_next  = timer_reg;
        dir_up_next = dir_up_reg;
        dir_dn_next = dir_dn_reg;
        clear       = '0;

        case (state_reg)
            S_IDLE: begin
                timer_next  = '0;
                dir_up_next = 1'b0;
                dir_dn_next = 1'b0;
                if (hit_cur) begin
                    state_next = S_DOOR;
                    clear      = cur_oh;
                    timer_next = DOOR_LOAD;
                end else if (above_any) begin
                    state_next  = S_MOVE_UP;
                    dir_up_next = 1'b1;
                end else if (below_any) begin
                    state_next  = S_MOVE_DN;
                    dir_dn_next = 1'b1;
                end
            end

            S_MOVE_UP, S_MOVE_DN: begin
                if (timer_reg != TRAVEL_LAST) begin
                    timer_next = timer_reg + 1'b1;
                end else begin
                    timer_next = '0;
                    if ((state_reg == S_MOVE_UP && floor_reg >= TOP_FLOOR) ||
                        (state_reg == S_MOVE_DN && floor_reg == 4'd0)) begin
                        // Nowhere to go; never reached while requests persist.
                        state_next  = S_IDLE;
                        dir_up_next = 1'b0;
                        dir_dn_next = 1'b0;
                    end else if (state_reg == S_MOVE_UP) begin
                        floor_next = floor_reg + 4'd1;
                        if (hit_up) begin
                            state_next = S_DOOR;
                            clear      = up_oh;
                            timer_next = DOOR_LOAD;
                        end else if (!above_next_any) begin
                            state_next  = S_IDLE;
                            dir_up_next = 1'b0;
                        end
                    end else begin
                        floor_next = floor_reg - 4'd1;
                        if (hit_dn) begin
                            state_next = S_DOOR;
                            clear      = dn_oh;
                            timer_next = DOOR_LOAD;
                        end else if (!below_next_any) begin
                            state_next  = S_IDLE;
                            dir_dn_next = 1'b0;
                        end
                    end
                end
            end

            S_DOOR: begin
                if (hit_cur) begin
                    // Same-floor call while open: extend rather than latch.
                    clear      = cur_oh;
                    timer_next = DOOR_LOAD;
`ifdef DOOR_HOLD_EN
                end else if (door_hold) begin
                    timer_next = DOOR_LOAD;
`endif
                end else if (timer_reg != '0) begin
                    timer_next = timer_reg - 1'b1;
                end else begin
                    timer_next  = '0;
                    dir_up_next = 1'b0;
                    dir_dn_next = 1'b0;
                    state_next  = S_IDLE;
                    // Keep the committed direction if possible, else reverse.
                    if (dir_dn_reg) begin
                        if (below_any) begin
                            state_next = S_MOVE_DN; dir_dn_next = 1'b1;
                        end else if (above_any) begin
                            state_next = S_MOVE_UP; dir_up_next = 1'b1;
                        end
                    end else begin
                        if (above_any) begin
                            state_next = S_MOVE_UP; dir_up_next = 1'b1;
                        end else if (below_any) begin
                            state_next = S_MOVE_DN; dir_dn_next = 1'b1;
                        end
                    end
                end
            end

            default: state_next = S_IDLE;
        endcase
    end

    assign pending_next = eff & ~clear;

    // Output logic
    always_comb begin
        moving    = (state_reg == S_MOVE_UP) || (state_reg == S_MOVE_DN);
        door_open = (state_reg == S_DOOR);
        dir_up    = dir_up_reg;
        dir_dn    = dir_dn_reg;
        floor     = floor_reg;
        pending   = pending_reg;
    end

endmodule

// File: tb/tb_elevator_floor_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for elevator_floor_ctrl (NUM_FLOORS=10, TRAVEL_CYCLES=4,
// DOOR_CYCLES=6). A procedural car model runs alongside the DUT and pushes
// the outputs it expects after every clock edge. A monitor pops them on the
// falling edge and compares. Directed scenarios come first, then random
// requests.
// ---------------------------------------------------------------------------
module tb_elevator_floor_ctrl;

    localparam int NF = 10;
    localparam int TC = 4;
    localparam int DC = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NF-1:0] req = '0;
`ifdef DOOR_HOLD_EN
    logic          door_hold = 1'b0;
`endif
    logic [3:0]    floor;
    logic          dir_up, dir_dn, moving, door_open;
    logic [NF-1:0] pending;

    int checks = 0;
    int failures = 0;

    elevator_floor_ctrl #(
        .NUM_FLOORS(NF), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
`ifdef DOOR_HOLD_EN
        .door_hold(door_hold),
`endif
        .floor(floor),
        .dir_up(dir_up),
        .dir_dn(dir_dn),
        .moving(moving),
        .door_open(door_open),
        .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]    fl;
        logic [NF-1:0] pend;
        logic          up;
        logic          dn;
        logic          mv;
        logic          dr;
    } snap_t;

    snap_t exp_q[$];

    // Model state: plain integers, direction as +1 / -1 / 0.
    int            m_floor;
    int            m_dir;
    logic [NF-1:0] m_pend;

    function automatic logic [NF-1:0] floors_above(input int f);
        logic [NF-1:0] m = '0;
        for (int i = 0; i < NF; i++) if (i > f) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [NF-1:0] floors_below(input int f);
        logic [NF-1:0] m = '0;
        for (int i = 0; i < NF; i++) if (i < f) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [NF-1:0] only(input int f);
        logic [NF-1:0] m = '0;
        m[f] = 1'b1;
        return m;
    endfunction

    function automatic logic hold_now();
`ifdef DOOR_HOLD_EN
        return door_hold;
`else
        return 1'b0;
`endif
    endfunction

    task automatic push(input logic mv, input logic dr);
        snap_t s;
        s.fl   = 4'(m_floor);
        s.pend = m_pend;
        s.up   = (m_dir == 1);
        s.dn   = (m_dir == -1);
        s.mv   = mv;
        s.dr   = dr;
        exp_q.push_back(s);
    endtask

    // The car behaviour: wait idle, open the door for DC cycles (restarting on
    // a same-floor call), travel TC cycles per floor, and pick the next
    // direction SCAN-style when the door closes.
    task automatic run_model();
        logic [NF-1:0] eff;
        int            mode;   // 0 waiting, 1 door open, 2 travelling
        int            left;
        m_floor = 0; m_dir = 0; m_pend = '0; mode = 0;
        forever begin
            if (mode == 0) begin
                @(posedge clk); eff = m_pend | req;
                if (eff[m_floor]) begin
                    m_pend = eff & ~only(m_floor); mode = 1; push(0, 1);
                end else if (|(eff & floors_above(m_floor))) begin
                    m_pend = eff; m_dir = 1; mode = 2; push(1, 0);
                end else if (|(eff & floors_below(m_floor))) begin
                    m_pend = eff; m_dir = -1; mode = 2; push(1, 0);
                end else begin
                    m_pend = eff; m_dir = 0; push(0, 0);
                end
            end else if (mode == 1) begin
                left = DC;
                while (mode == 1) begin
                    @(posedge clk); eff = m_pend | req;
                    if (eff[m_floor] || hold_now()) begin
                        m_pend = eff & ~only(m_floor); left = DC; push(0, 1);
                    end else begin
                        m_pend = eff;
                        left--;
                        if (left > 0) begin
                            push(0, 1);
                        end else begin
                            logic up_w, dn_w;
                            up_w = |(eff & floors_above(m_floor));
                            dn_w = |(eff & floors_below(m_floor));
                            if (m_dir == -1 && dn_w)      m_dir = -1;
                            else if (m_dir == -1 && up_w) m_dir = 1;
                            else if (up_w)                m_dir = 1;
                            else if (dn_w)                m_dir = -1;
                            else                          m_dir = 0;
                            mode = (m_dir == 0) ? 0 : 2;
                            push(m_dir != 0, 0);
                        end
                    end
                end
            end else begin
                for (int k = 1; k <= TC; k++) begin
                    @(posedge clk); eff = m_pend | req;
                    if (k < TC) begin
                        m_pend = eff; push(1, 0);
                    end else begin
                        m_floor += m_dir;
                        if (eff[m_floor]) begin
                            m_pend = eff & ~only(m_floor); mode = 1; push(0, 1);
                        end else if ((m_dir == 1 && |(eff & floors_above(m_floor))) ||
                                     (m_dir == -1 && |(eff & floors_below(m_floor)))) begin
                            m_pend = eff; push(1, 0);
                        end else begin
                            m_pend = eff; m_dir = 0; mode = 0; push(0, 0);
                        end
                    end
                end
            end
        end
    endtask

    task automatic run_monitor();
        snap_t e;
        logic  prev_door = 1'b0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (floor !== e.fl || pending !== e.pend || dir_up !== e.up ||
                    dir_dn !== e.dn || moving !== e.mv || door_open !== e.dr) begin
                    failures++;
                    $display("FAIL cycle_outputs t=%0t got fl=%0d pend=%b up=%b dn=%b mv=%b dr=%b want fl=%0d pend=%b up=%b dn=%b mv=%b dr=%b",
                             $time, floor, pending, dir_up, dir_dn, moving, door_open,
                             e.fl, e.pend, e.up, e.dn, e.mv, e.dr);
                end
                checks++;
                if (moving && door_open) begin
                    failures++;
                    $display("FAIL move_door_exclusive t=%0t got moving=1 door_open=1 want not both", $time);
                end
                checks++;
                if (dir_up && dir_dn) begin
                    failures++;
                    $display("FAIL dir_exclusive t=%0t got dir_up=1 dir_dn=1 want not both", $time);
                end
                if (door_open && !prev_door)
                    $display("stop floor=%0d dir_up=%b dir_dn=%b pending=%b t=%0t",
                             floor, dir_up, dir_dn, pending, $time);
                prev_door = door_open;
            end
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (floor !== 4'd0 || pending !== '0 || dir_up !== 1'b0 || dir_dn !== 1'b0 ||
            moving !== 1'b0 || door_open !== 1'b0) begin
            failures++;
            $display("FAIL %s got fl=%0d pend=%b up=%b dn=%b mv=%b dr=%b want all zero",
                     name, floor, pending, dir_up, dir_dn, moving, door_open);
        end
    endtask

    task automatic pulse(input logic [NF-1:0] r);
        @(negedge clk); req = r;
        @(negedge clk); req = '0;
    endtask

    // Bounded wait on the DUT for stimulus timing only.
    task automatic wait_door_at(input int f, input string name);
        int n = 0;
        while (!(door_open && floor == 4'(f)) && n < 100) begin
            @(negedge clk); n++;
        end
        if (n >= 100) begin
            checks++; failures++;
            $display("FAIL %s timeout got floor=%0d door_open=%b want door open at %0d",
                     name, floor, door_open, f);
        end
    endtask

    initial begin
        int n;
        // Power-up reset state.
        #3 check_reset_outputs("reset_initial");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a move: head for 5, abort between 3 and 4.
        pulse(NF'(1 << 5));
        n = 0;
        while (!(floor == 4'd3 && moving) && n < 100) begin
            @(negedge clk); n++;
        end
        checks++;
        if (n >= 100) begin
            failures++;
            $display("FAIL reach_floor3 timeout got floor=%0d moving=%b want 3/1", floor, moving);
        end
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset_mid_move");
        @(negedge clk);
        check_reset_outputs("reset_held");
        rst_n = 1'b1;

        fork
            run_model();
            run_monitor();
        join_none

        // Same-floor call from idle, then a trip to 3.
        pulse(NF'(1 << 0));
        repeat (12) @(negedge clk);
        pulse(NF'(1 << 3));
        repeat (40) @(negedge clk);

        // SCAN ordering: while passing 5 upward with 7 pending, call 2 and 6.
        pulse(NF'(1 << 7));
        repeat (8) @(negedge clk);
        pulse(NF'((1 << 2) | (1 << 6)));
        repeat (90) @(negedge clk);

        // Door reload on the 4th open cycle at floor 4.
        @(negedge clk); req = NF'(1 << 4);
        @(negedge clk); req = '0;
        wait_door_at(4, "reach_floor4");
        repeat (3) @(negedge clk);
        req = NF'(1 << 4);
        @(negedge clk); req = '0;
        repeat (20) @(negedge clk);

`ifdef DOOR_HOLD_EN
        // Hold the door for 20 cycles at floor 8.
        @(negedge clk); req = NF'(1 << 8);
        @(negedge clk); req = '0;
        wait_door_at(8, "reach_floor8");
        door_hold = 1'b1;
        repeat (20) @(negedge clk);
        door_hold = 1'b0;
        repeat (12) @(negedge clk);
`endif

        // Random traffic: sparse pulses, occasional multi-bit or level requests.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            case ($urandom_range(0, 15))
                0, 1:    req = NF'(1 << $urandom_range(0, NF - 1));
                2:       req = NF'($urandom_range(0, (1 << NF) - 1));
                3:       req = req;
                default: req = '0;
            endcase
`ifdef DOOR_HOLD_EN
            door_hold = ($urandom_range(0, 15) == 0);
`endif
        end
        @(negedge clk); req = '0;
`ifdef DOOR_HOLD_EN
        door_hold = 1'b0;
`endif
        repeat (150) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/elevator_floor_ctrl.md
Name: elevator_floor_ctrl

Overview:
- Upstream stage of the seven-segment floor display.
- Latches hall and car floor requests and runs a SCAN-style car state machine with per-floor travel and door timers.
- Drives the current floor as a 4-bit binary nibble `floor[3:0]`, which wires directly to the decoder inputs (`floor[3]` is the MSB and goes to x3, down to `floor[0]` on x0).
- Also provides direction and door status for indicator LEDs.

Parameters:
- `NUM_FLOORS`, default 10: number of served floors, numbered 0..NUM_FLOORS-1. Legal range 2..16.
- `TRAVEL_CYCLES`, default 50: clock cycles spent moving between adjacent floors. Must be ≥1.
- `DOOR_CYCLES`, default 100: clock cycles the door stays open per stop. Must be ≥1.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_FLOORS  request per floor. Level or pulse; a bit high for ≥1 rising edge registers that floor.
- `floor`  out  4  current floor, binary; feeds the seven-seg decoder.
- `dir_up`  out  1  car moving up, or committed to up.
- `dir_dn`  out  1  car moving down, or committed to down.
- `moving`  out  1  high in MOVE_UP or MOVE_DN.
- `door_open`  out  1  high in DOOR.
- `pending`  out  NUM_FLOORS  latched, unserved requests.

Behaviour:
- **Reset (async, while `rst_n`=0):**
  - state=IDLE, `floor`=0, `pending`=0, all timers=0.
  - `dir_up`=`dir_dn`=`moving`=`door_open`=0.
  - A reset mid-move or mid-door aborts immediately. No request survives reset.
- **Request latching, each cycle:** `pending` <= (`pending` | `req`) & ~clear.
  - clear is a one-hot of the floor being served this cycle (see arrival / IDLE), else 0.
  - Clear wins over a simultaneous set of the same bit.
- **IDLE:**
  - If `pending[floor]`: go to DOOR, clear that bit, load door timer.
  - Else if any pending bit above `floor`: go to MOVE_UP, `dir_up`=1.
  - Else if any pending bit below `floor`: go to MOVE_DN, `dir_dn`=1.
  - Up has priority when both above and below are pending.
  - Otherwise stay in IDLE, with `dir_up`=`dir_dn`=0.
- **MOVE_UP / MOVE_DN:**
  - Travel timer counts 0..TRAVEL_CYCLES-1.
  - On terminal count, `floor` steps ±1 and the timer returns to 0.
  - `floor` changes exactly once per TRAVEL_CYCLES cycles.
  - Arrival: if the new floor is pending, go to DOOR in the same edge that updates `floor`, and clear that bit. Otherwise keep moving.
  - `floor` never leaves 0..NUM_FLOORS-1. If no request remains in the travel direction on arrival, go to IDLE; this is defensive only, since requests are never withdrawn.
  - A request for the departed floor while between floors is latched and served later.
- **DOOR:**
  - `door_open`=1 for exactly DOOR_CYCLES cycles; `dir_*` holds the last committed direction.
  - A `req` for the current floor during DOOR reloads the door timer and is not latched.
  - When the timer expires:
    - Continue in the current direction if requests remain that way.
    - Else reverse if requests remain the other way.
    - Else go to IDLE and clear `dir_*`.
  - Leaving DOOR clears `door_open` on the same edge that sets `moving`.
- **Output constraints:**
  - `moving` and `door_open` are never high together.
  - `dir_up` and `dir_dn` are never high together.
  - `floor` is stable for the whole of DOOR and IDLE.
- **Width rules:**
  - Timers are wide enough for max(TRAVEL_CYCLES, DOOR_CYCLES)-1.
  - `floor` is 4 bits, zero-extended when NUM_FLOORS < 16.
  - "Above"/"below" tests are masks on `pending`, relative to `floor`.

Optional Feature:
- Macro: `DOOR_HOLD_EN`.
- **Defined:** adds input port `door_hold` (1 bit).
  - While `door_hold`=1 in DOOR, the door timer is held at its reload value, so the door stays open.
  - The countdown restarts from the full DOOR_CYCLES once `door_hold` drops.
  - `door_hold` has no effect in other states.
- **Not defined:** no `door_hold` port exists; door timing is purely DOOR_CYCLES plus same-floor reload.

Test Plan:
All cases use NUM_FLOORS=10, TRAVEL_CYCLES=4, DOOR_CYCLES=6.
1. Reset mid-move: assert `rst_n`=0 with the car at floor 3 in MOVE_UP.
   - Required: `floor`=0, `pending`=0, all flags 0 immediately, with no clock edge needed.
2. From reset, pulse `req[0]` for 1 cycle.
   - Required: `pending[0]` never set visibly; DOOR next edge; `door_open` high for exactly 6 cycles; then IDLE.
3. From floor 0, pulse `req[3]`.
   - Required: `floor` steps 1, 2, 3 at 4-cycle intervals.
   - `door_open` rises on the same edge `floor` becomes 3, and `pending[3]` clears on that edge.
4. SCAN ordering: at floor 5 moving up with `req[7]` pending, pulse `req[2]` and `req[6]`.
   - Required: stops at 6, then 7, then reverses and stops at 2.
   - `dir_dn` asserts only after the door at 7 closes.
5. Door reload: during DOOR at floor 4, pulse `req[4]` on the 4th open cycle.
   - Required: `door_open` lasts 4+6=10 cycles total; `pending[4]` stays 0.
6. `DOOR_HOLD_EN` build: hold `door_hold`=1 for 20 cycles in DOOR.
   - Required: `door_open` stays 1 throughout and falls exactly 6 cycles after `door_hold` deasserts.
